irq_clear_master: RTL and testbench
===================================

# irq_clear_master

Interrupt-acknowledge controller and peripheral-bus initiator for the processor's interrupt path. It samples the level `int_req` lines of up to `N_SRC` memory-mapped peripherals (timers and similar), picks the highest-priority enabled source, and presents it to the CPU as one request plus vector. On CPU acknowledge it acts as bus initiator: it writes the source's CR1 register (address 2'b01) to clear that peripheral's request latch, then holds the source in service until end-of-interrupt.

## Interface
- `N_SRC`, default 4: number of interrupt sources; index 0 has the highest priority.
- `VEC_W`, default 2: vector width, equal to clog2(`N_SRC`).
- `TIMEOUT`, default 15: maximum number of CLEAR-state cycles without `m_rdy` before the clear write is abandoned.
- One clock; reset is asynchronous and active-high. Ports are named `clk` and `rst`.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous active-high reset.
- `irq_in`  in  N_SRC: level interrupt requests from the peripherals' `int_req`.
- `irq_en`  in  N_SRC: per-source enable; disabled sources are never selected.
- `cpu_irq`  out  1: interrupt request to the CPU.
- `cpu_vec`  out  VEC_W: index of the latched source; valid while `cpu_irq` or `in_service` is high.
- `cpu_ack`  in  1: single-cycle CPU acknowledge.
- `cpu_eoi`  in  1: single-cycle end-of-interrupt.
- `in_service`  out  1: a source is being serviced.
- `err_timeout`  out  1: sticky flag; the clear write received no `m_rdy`.
- `err_clr`  in  1: clears `err_timeout`.
- `m_sel`  out  N_SRC: one-hot peripheral select.
- `m_we`  out  1: write strobe.
- `m_re`  out  1: read strobe; always 0.
- `m_addr`  out  2: register index; 2'b01 during a clear.
- `m_wdata`  out  16: write data; always 16'h0000.
- `m_rdy`  in  1: OR of the selected peripherals' `rdy`; may be combinational from `m_sel`.

## Operation
- FSM states: IDLE, PEND, CLEAR, SETTLE, SERVICE.
- IDLE: if `irq_in & irq_en` is nonzero, latch the lowest set index into `cpu_vec` and go to PEND.
- PEND: `cpu_irq`=1.
  - On `cpu_ack`, go to CLEAR.
  - The latched vector is never retracted, even if its source drops or is disabled.
- CLEAR: drive `m_sel`=one-hot(`cpu_vec`), `m_we`=1, `m_addr`=2'b01, `m_wdata`=0.
  - If `m_rdy` is high at the edge, go to SETTLE.
  - Otherwise increment the wait counter.
  - When the counter reaches `TIMEOUT`, set `err_timeout` and go to SERVICE.
- SETTLE: one cycle with all bus outputs idle, so the peripheral's cleared `int_req` propagates. Then go to SERVICE.
- SERVICE: `in_service`=1. On `cpu_eoi`, go to IDLE. No nesting; new requests wait.
- `cpu_ack` outside PEND and `cpu_eoi` outside SERVICE are ignored.
- `err_timeout`: set has priority over a simultaneous `err_clr`.
- The wait counter is clog2(`TIMEOUT`+1) bits and is zeroed on entry to CLEAR.

## Timing
- Reset: state IDLE. `cpu_irq`, `cpu_vec`, `in_service`, `err_timeout`, `m_sel`, `m_we`, `m_re`, `m_addr`, `m_wdata` and the counter are all 0.
- Reset mid-operation takes effect immediately and asynchronously. The bus write is dropped; outputs go to the reset values without waiting for a clock.
- All outputs are registered, or decoded from registered state only.
- Request latency: `irq_in` seen high at edge t in IDLE gives `cpu_irq`=1 and a valid `cpu_vec` after edge t.
- `cpu_ack` sampled at edge t in PEND: `cpu_irq`=0 and `m_sel`/`m_we` asserted after t.
- With a single-cycle responder (`m_rdy` = sel), the bus write lasts exactly 1 cycle.
  - `m_sel` falls after t+1.
  - SETTLE occupies t+1..t+2.
  - `in_service` rises after t+2.
- `cpu_eoi` at edge u: `in_service`=0 after u. IDLE evaluates requests at edge u+1, so there is at least one idle cycle between services.
- Timeout: with `m_rdy` stuck low, exactly `TIMEOUT` CLEAR cycles occur, then `err_timeout`=1 and `in_service`=1 together.

## Structure
- Package `irq_pkg` holds:
  - the state enum;
  - `CR1_ADDR` = 2'b01;
  - `CLR_WDATA` = 16'h0000.
- Sub-module `irq_prio_enc` is a parameterised combinational lowest-index priority encoder. It outputs `any` and `idx`.
- The FSM, the bus driver and the counter stay in `irq_clear_master`.

## Test plan
- `irq_in`=4'b0100 with all sources enabled, `cpu_ack` two cycles later, `m_rdy` tied to `|m_sel`:
  - expect `cpu_vec`=2;
  - expect `m_sel`=4'b0100, `m_we`=1, `m_addr`=2'b01 for one cycle;
  - expect `in_service` two cycles later.
- `irq_in`=4'b1010 with `irq_en`=4'b1101 -> `cpu_vec`=3; source 1 is never selected.
- `m_rdy` held 0 -> `m_sel` high for 15 cycles, then `err_timeout`=1 and `in_service`=1. `err_clr` then gives `err_timeout`=0.
- A new `irq_in`[0] arrives during SERVICE of source 2 -> no `cpu_irq` until the cycle after `cpu_eoi`; then `cpu_vec`=0.
- `rst` asserted mid-CLEAR, off the clock edge -> `m_sel`, `m_we` and `cpu_irq` are 0 before the next edge. After release, a pending `irq_in` is re-requested.
- `cpu_ack` pulsed in IDLE and `cpu_eoi` pulsed in PEND -> no state change.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt-acknowledge controller.
// Imported by the encoder and the controller top.
package irq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_CLEAR,
    S_SETTLE,
    S_SERVICE
  } state_t;

  localparam logic [1:0]  CR1_ADDR  = 2'b01;
  localparam logic [15:0] CLR_WDATA = 16'h0000;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder.
// Index 0 is the highest priority.
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [W-1:0] idx
);

  assign any = |req;

  // Scan downward so the lowest set index is the last to win.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/irq_clear_master.sv
// Interrupt acknowledge controller: selects a source, clears its
// request latch over the peripheral bus, and tracks service until EOI.
module irq_clear_master #(
  parameter int N_SRC   = 4,
  parameter int VEC_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_en,
  output logic             cpu_irq,
  output logic [VEC_W-1:0] cpu_vec,
  input  logic             cpu_ack,
  input  logic             cpu_eoi,
  output logic             in_service,
  output logic             err_timeout,
  input  logic             err_clr,
  output logic [N_SRC-1:0] m_sel,
  output logic             m_we,
  output logic             m_re,
  output logic [1:0]       m_addr,
  output logic [15:0]      m_wdata,
  input  logic             m_rdy
);

  import irq_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state, state_n;
  logic [VEC_W-1:0] vec, vec_n;
  logic [CW-1:0]    cnt, cnt_n, cnt_inc;
  logic             err, err_n;
  logic             any;
  logic [VEC_W-1:0] idx;

  irq_prio_enc #(
    .N (N_SRC),
    .W (VEC_W)
  ) u_enc (
    .req (irq_in & irq_en),
    .any (any),
    .idx (idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      vec   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      vec   <= vec_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    err_n   = err_clr ? 1'b0 : err;
    unique case (state)
      S_IDLE: begin
        if (any) begin
          vec_n   = idx;
          state_n = S_PEND;
        end
      end
      S_PEND: begin
        if (cpu_ack) begin
          cnt_n   = '0;
          state_n = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (m_rdy) begin
          state_n = S_SETTLE;
        end else begin
          cnt_n = cnt_inc;
          // Timeout set wins over a same-cycle err_clr.
          if (cnt_inc == CW'(TIMEOUT)) begin
            err_n   = 1'b1;
            state_n = S_SERVICE;
          end
        end
      end
      S_SETTLE: state_n = S_SERVICE;
      S_SERVICE: begin
        if (cpu_eoi) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign cpu_irq     = (state == S_PEND);
  assign in_service  = (state == S_SERVICE);
  assign cpu_vec     = vec;
  assign err_timeout = err;
  assign m_we        = (state == S_CLEAR);
  assign m_sel       = m_we ? (N_SRC'(1) << vec) : '0;
  assign m_addr      = m_we ? CR1_ADDR : 2'b00;
  assign m_wdata     = CLR_WDATA;
  assign m_re        = 1'b0;

endmodule

// File: tb/tb_irq_clear_master.sv
// Self-checking bench for irq_clear_master with directed scenarios
// and a randomized run checked against a behavioural model.
module tb_irq_clear_master;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_in = '0;
  logic [3:0] irq_en = '0;
  logic       cpu_irq;
  logic [1:0] cpu_vec;
  logic       cpu_ack = 1'b0;
  logic       cpu_eoi = 1'b0;
  logic       in_service;
  logic       err_timeout;
  logic       err_clr = 1'b0;
  logic [3:0] m_sel;
  logic       m_we;
  logic       m_re;
  logic [1:0] m_addr;
  logic [15:0] m_wdata;
  logic       m_rdy;
  logic       rdy_auto = 1'b1;
  logic       rdy_force = 1'b0;

  int checks = 0;
  int failures = 0;

  assign m_rdy = rdy_auto ? |m_sel : rdy_force;

  always #5 clk = ~clk;

  irq_clear_master #(
    .N_SRC   (4),
    .VEC_W   (2),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .irq_en      (irq_en),
    .cpu_irq     (cpu_irq),
    .cpu_vec     (cpu_vec),
    .cpu_ack     (cpu_ack),
    .cpu_eoi     (cpu_eoi),
    .in_service  (in_service),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .m_sel       (m_sel),
    .m_we        (m_we),
    .m_re        (m_re),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rdy       (m_rdy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: highest priority enabled source, -1 when none.
  function automatic int pick(input logic [3:0] req, input logic [3:0] en);
    logic [3:0] v;
    v = req & en;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic pulse_ack();
    cpu_ack = 1'b1;
    cyc();
    cpu_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    cpu_eoi = 1'b1;
    cyc();
    cpu_eoi = 1'b0;
  endtask

  task automatic drain();
    int n;
    irq_in = '0;
    n = 0;
    while (!in_service && n < 40) begin
      n++;
      cyc();
    end
    pulse_eoi();
    cyc();
  endtask

  task automatic test_reset();
    logic [28:0] obs;
    rst = 1'b1;
    irq_in = 4'hF;
    irq_en = 4'hF;
    repeat (3) cyc();
    obs = {cpu_irq, cpu_vec, in_service, err_timeout, m_sel,
           m_we, m_re, m_addr, m_wdata};
    checks++;
    if (obs !== 29'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", obs);
    end
    irq_in = '0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    irq_en = 4'hF;
    irq_in = 4'b0100;
    rdy_auto = 1'b1;
    cyc();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_vec !== 2'd2) begin
      failures++;
      $display("FAIL basic_req irq=%b vec=%0d want 1/2", cpu_irq, cpu_vec);
    end
    cyc();
    pulse_ack();
    irq_in = '0;
    checks++;
    if (m_sel !== 4'b0100 || m_we !== 1'b1 || m_addr !== 2'b01 ||
        cpu_irq !== 1'b0 || m_wdata !== 16'h0 || m_re !== 1'b0) begin
      failures++;
      $display("FAIL basic_bus sel=%b we=%b addr=%b irq=%b", m_sel, m_we,
               m_addr, cpu_irq);
    end
    cyc();
    checks++;
    if (m_sel !== 4'b0 || m_we !== 1'b0 || in_service !== 1'b0) begin
      failures++;
      $display("FAIL basic_settle sel=%b we=%b ins=%b want 0/0/0", m_sel,
               m_we, in_service);
    end
    cyc();
    checks++;
    if (in_service !== 1'b1 || cpu_vec !== 2'd2) begin
      failures++;
      $display("FAIL basic_service ins=%b vec=%0d want 1/2", in_service,
               cpu_vec);
    end
    pulse_eoi();
    checks++;
    if (in_service !== 1'b0 || cpu_irq !== 1'b0) begin
      failures++;
      $display("FAIL basic_eoi ins=%b irq=%b want 0/0", in_service, cpu_irq);
    end
    cyc();
  endtask

  task automatic test_enable_mask();
    irq_in = 4'b1010;
    irq_en = 4'b1101;
    cyc();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_vec !== 2'd3) begin
      failures++;
      $display("FAIL mask_vec irq=%b vec=%0d want 1/3", cpu_irq, cpu_vec);
    end
    pulse_ack();
    checks++;
    if (m_sel !== 4'b1000) begin
      failures++;
      $display("FAIL mask_sel got=%b want=1000", m_sel);
    end
    drain();
    irq_en = 4'hF;
  endtask

  task automatic test_timeout();
    int n;
    irq_in = 4'b0001;
    irq_en = 4'hF;
    rdy_auto = 1'b0;
    rdy_force = 1'b0;
    cyc();
    irq_in = '0;
    pulse_ack();
    // err_clr held through the wait: a same-edge set must still win.
    err_clr = 1'b1;
    n = 0;
    while (m_sel != 4'b0 && n < 40) begin
      n++;
      cyc();
    end
    err_clr = 1'b0;
    checks++;
    if (n !== TO) begin
      failures++;
      $display("FAIL timeout_len got=%0d want=%0d", n, TO);
    end
    checks++;
    if (err_timeout !== 1'b1 || in_service !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flags err=%b ins=%b want 1/1", err_timeout,
               in_service);
    end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clr got=%b want=0", err_timeout);
    end
    rdy_auto = 1'b1;
    pulse_eoi();
    cyc();
  endtask

  task automatic test_no_nesting();
    irq_in = 4'b0100;
    cyc();
    pulse_ack();
    irq_in = '0;
    repeat (2) cyc();
    irq_in = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (cpu_irq !== 1'b0 || in_service !== 1'b1) begin
        failures++;
        $display("FAIL nest_hold%0d irq=%b ins=%b want 0/1", i, cpu_irq,
                 in_service);
      end
    end
    pulse_eoi();
    checks++;
    if (cpu_irq !== 1'b0) begin
      failures++;
      $display("FAIL nest_gap irq=%b want 0", cpu_irq);
    end
    cyc();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_vec !== 2'd0) begin
      failures++;
      $display("FAIL nest_next irq=%b vec=%0d want 1/0", cpu_irq, cpu_vec);
    end
    pulse_ack();
    drain();
  endtask

  task automatic test_async_reset();
    irq_in = 4'b0010;
    rdy_auto = 1'b0;
    rdy_force = 1'b0;
    cyc();
    pulse_ack();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_sel !== 4'b0 || m_we !== 1'b0 || cpu_irq !== 1'b0) begin
      failures++;
      $display("FAIL async_rst sel=%b we=%b irq=%b want 0", m_sel, m_we,
               cpu_irq);
    end
    #2;
    rst = 1'b0;
    rdy_auto = 1'b1;
    cyc();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_vec !== 2'd1) begin
      failures++;
      $display("FAIL async_rereq irq=%b vec=%0d want 1/1", cpu_irq, cpu_vec);
    end
    pulse_ack();
    drain();
  endtask

  task automatic test_ignored();
    irq_in = '0;
    cpu_ack = 1'b1;
    cyc();
    cpu_ack = 1'b0;
    cyc();
    checks++;
    if (cpu_irq !== 1'b0 || m_we !== 1'b0 || in_service !== 1'b0) begin
      failures++;
      $display("FAIL ign_ack irq=%b we=%b ins=%b want 0", cpu_irq, m_we,
               in_service);
    end
    irq_in = 4'b0100;
    cyc();
    pulse_eoi();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_vec !== 2'd2 || m_we !== 1'b0) begin
      failures++;
      $display("FAIL ign_eoi irq=%b vec=%0d we=%b want 1/2/0", cpu_irq,
               cpu_vec, m_we);
    end
    pulse_ack();
    drain();
  endtask

  task automatic test_random();
    int exp_vec, k, d, n, s, exp_bus, exp_settle;
    logic exp_err;
    for (int it = 0; it < 40; it++) begin
      irq_in = 4'($urandom);
      irq_en = 4'($urandom);
      exp_vec = pick(irq_in, irq_en);
      cyc();
      if (exp_vec < 0) begin
        cyc();
        checks++;
        if (cpu_irq !== 1'b0) begin
          failures++;
          $display("FAIL rnd_none it=%0d irq=%b want 0", it, cpu_irq);
        end
        continue;
      end
      d = $urandom_range(0, 3);
      for (int j = 0; j <= d; j++) begin
        checks++;
        if (cpu_irq !== 1'b1 || cpu_vec !== 2'(exp_vec)) begin
          failures++;
          $display("FAIL rnd_pend it=%0d irq=%b vec=%0d want 1/%0d", it,
                   cpu_irq, cpu_vec, exp_vec);
        end
        irq_in = 4'($urandom);
        irq_en = 4'($urandom);
        if (j < d) cyc();
      end
      k = $urandom_range(0, 17);
      exp_bus = (k < TO) ? k + 1 : TO;
      exp_settle = (k < TO) ? 1 : 0;
      exp_err = (k >= TO);
      rdy_auto = 1'b0;
      rdy_force = 1'b0;
      pulse_ack();
      n = 0;
      while (m_sel != 4'b0 && n < 40) begin
        checks++;
        if (m_sel !== 4'(1 << exp_vec) || m_addr !== 2'b01) begin
          failures++;
          $display("FAIL rnd_sel it=%0d sel=%b addr=%b", it, m_sel, m_addr);
        end
        rdy_force = (n >= k);
        n++;
        cyc();
      end
      rdy_force = 1'b0;
      s = 0;
      while (!in_service && s < 5) begin
        s++;
        cyc();
      end
      checks++;
      if (n !== exp_bus || s !== exp_settle || err_timeout !== exp_err) begin
        failures++;
        $display("FAIL rnd_seq it=%0d k=%0d bus=%0d/%0d settle=%0d/%0d err=%b",
                 it, k, n, exp_bus, s, exp_settle, err_timeout);
      end
      cyc();
      checks++;
      if (cpu_irq !== 1'b0 || in_service !== 1'b1) begin
        failures++;
        $display("FAIL rnd_svc it=%0d irq=%b ins=%b", it, cpu_irq, in_service);
      end
      pulse_eoi();
      irq_in = '0;
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      rdy_auto = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable_mask();
    test_timeout();
    test_no_nesting();
    test_async_reset();
    test_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
